mem_wb_elastic_reg: RTL and testbench

Parametrised successor to the MEM/WB pipeline register for the Lab-4 pipelined CPU. It carries the MEM-stage write-back bundle (write-enable, mem-to-reg select, load data, ALU result, destination register, instruction type/number tags) to the WB stage. It adds a valid/ready handshake with a two-entry skid buffer, synchronous flush, bubble gating of the register-file write enable, a pre-muxed write-back value and a retired-instruction counter. It sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_elastic_reg.sv | 134 +++++++++++++
 tb/tb_mem_wb_elastic_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB pipeline register with valid/ready handshake and two-entry skid buffer.
// Carries the write-back bundle, pre-muxes the WB value and counts retired beats.
module mem_wb_elastic_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned RET_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_wreg,
    input  logic               in_m2reg,
    input  logic [DATA_W-1:0]  in_mem_data,
    input  logic [DATA_W-1:0]  in_alu_out,
    input  logic [RADDR_W-1:0] in_rdrt,
    input  logic [TAG_W-1:0]   in_ins_type,
    input  logic [TAG_W-1:0]   in_ins_number,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_wreg,
    output logic               out_m2reg,
    output logic [DATA_W-1:0]  out_mem_data,
    output logic [DATA_W-1:0]  out_alu_out,
    output logic [RADDR_W-1:0] out_rdrt,
    output logic [TAG_W-1:0]   out_ins_type,
    output logic [TAG_W-1:0]   out_ins_number,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic [RET_W-1:0]   retired
);

    typedef struct packed {
        logic               wreg;
        logic               m2reg;
        logic [DATA_W-1:0]  mem_data;
        logic [DATA_W-1:0]  alu_out;
        logic [RADDR_W-1:0] rdrt;
        logic [TAG_W-1:0]   ins_type;
        logic [TAG_W-1:0]   ins_number;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   drain;

    always_comb begin
        in_beat            = '0;
        in_beat.wreg       = in_wreg;
        in_beat.m2reg      = in_m2reg;
        in_beat.mem_data   = in_mem_data;
        in_beat.alu_out    = in_alu_out;
        in_beat.rdrt       = in_rdrt;
        in_beat.ins_type   = in_ins_type;
        in_beat.ins_number = in_ins_number;
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Handshake flags are registered alongside the state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            retired     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (drain) retired <= retired + RET_W'(1);
            if (flush) begin
                state       <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state)
                    EMPTY: if (accept) begin
                        main_q      <= in_beat;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                    ONE: begin
                        if (accept && drain) begin
                            main_q <= in_beat;
                        end else if (accept) begin
                            skid_q     <= in_beat;
                            state      <= FULL;
                            in_ready_q <= 1'b0;
                        end else if (drain) begin
                            state       <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                    FULL: if (drain) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                    default: begin
                        state       <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_wreg       = out_valid_q & main_q.wreg;
    assign out_m2reg      = main_q.m2reg;
    assign out_mem_data   = main_q.mem_data;
    assign out_alu_out    = main_q.alu_out;
    assign out_rdrt       = main_q.rdrt;
    assign out_ins_type   = main_q.ins_type;
    assign out_ins_number = main_q.ins_number;
    assign out_wb_data    = main_q.m2reg ? main_q.mem_data : main_q.alu_out;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Self-checking bench for mem_wb_elastic_reg: directed sequences, a vector table
// and random traffic compared against a queue-based reference model.
module tb_mem_wb_elastic_reg;

    localparam int unsigned RET_W = 4;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rdrt;
        logic [3:0]  typ;
        logic [3:0]  num;
    } beat_t;

    typedef struct {
        bit          v;
        bit          ordy;
        bit          fl;
        logic [31:0] alu;
        bit          exp_ov;
        bit          exp_ir;
        logic [31:0] exp_alu;
        int          exp_ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic flush = 1'b0;
    beat_t drv = '0;

    logic             in_ready, out_valid, out_wreg, out_m2reg;
    logic [31:0]      out_mem_data, out_alu_out, out_wb_data;
    logic [4:0]       out_rdrt;
    logic [3:0]       out_ins_type, out_ins_number;
    logic [RET_W-1:0] retired;

    int total = 0;
    int bad = 0;

    beat_t            q[$];
    logic [RET_W-1:0] mret = '0;

    mem_wb_elastic_reg #(.DATA_W(32), .RADDR_W(5), .TAG_W(4), .RET_W(RET_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wreg(drv.wreg), .in_m2reg(drv.m2reg), .in_mem_data(drv.mem),
        .in_alu_out(drv.alu), .in_rdrt(drv.rdrt), .in_ins_type(drv.typ),
        .in_ins_number(drv.num), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_wreg(out_wreg),
        .out_m2reg(out_m2reg), .out_mem_data(out_mem_data), .out_alu_out(out_alu_out),
        .out_rdrt(out_rdrt), .out_ins_type(out_ins_type), .out_ins_number(out_ins_number),
        .out_wb_data(out_wb_data), .retired(retired)
    );

    always #5 clk = ~clk;

    // Reference: a bounded FIFO of at most two beats plus a wrapping drain count.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            mret = '0;
        end else begin
            automatic bit acc = in_valid && (q.size() < 2);
            automatic bit drn = (q.size() > 0) && out_ready;
            if (drn) begin
                void'(q.pop_front());
                mret = mret + 1'b1;
            end
            if (flush) q.delete();
            else if (acc) q.push_back(drv);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_retired", 32'(retired), 32'(mret));
        if (q.size() > 0) begin
            chk("m_wreg", 32'(out_wreg), 32'(q[0].wreg));
            chk("m_m2reg", 32'(out_m2reg), 32'(q[0].m2reg));
            chk("m_mem", out_mem_data, q[0].mem);
            chk("m_alu", out_alu_out, q[0].alu);
            chk("m_rdrt", 32'(out_rdrt), 32'(q[0].rdrt));
            chk("m_type", 32'(out_ins_type), 32'(q[0].typ));
            chk("m_num", 32'(out_ins_number), 32'(q[0].num));
            chk("m_wb", out_wb_data, q[0].m2reg ? q[0].mem : q[0].alu);
        end else begin
            chk("m_wreg_bubble", 32'(out_wreg), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vt[12];
    logic [RET_W-1:0] base;
    logic [31:0] expect_alu;

    initial begin
        // Reset state, observed while still in reset.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_wreg", 32'(out_wreg), 32'd0);
        chk("rst_wb_data", out_wb_data, 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        rst = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat.
        out_ready = 1'b1; in_valid = 1'b1;
        drv = '0; drv.wreg = 1'b1; drv.alu = 32'h0000_1234; drv.rdrt = 5'd5;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_wb", out_wb_data, 32'h0000_1234);
        chk("single_rdrt", 32'(out_rdrt), 32'd5);
        step();
        chk("single_retired", 32'(retired), 32'd1);
        chk("single_empty", 32'(out_valid), 32'd0);

        // Streaming: 8 back-to-back beats.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            drv = '0; drv.wreg = 1'b1; drv.alu = 32'h100 + 32'(i);
            step();
            chk("stream_order", out_alu_out, 32'h100 + 32'(i));
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_retired", 32'(retired), 32'd9);

        // m2reg select, then bubble gating with a held wreg=1.
        in_valid = 1'b1; out_ready = 1'b0;
        drv = '0; drv.wreg = 1'b1; drv.m2reg = 1'b1; drv.mem = 32'hDEAD_BEEF; drv.alu = 32'h1;
        step();
        in_valid = 1'b0;
        chk("m2reg_wb", out_wb_data, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        step();
        chk("bubble_wreg", 32'(out_wreg), 32'd0);

        // Stall/skid and flush table; exp_ret is relative to the count at table start.
        vt[0]  = '{1, 0, 0, 32'hA, 1, 1, 32'hA, 0};
        vt[1]  = '{1, 0, 0, 32'hB, 1, 0, 32'hA, 0};
        vt[2]  = '{1, 0, 0, 32'hC, 1, 0, 32'hA, 0};
        vt[3]  = '{1, 1, 0, 32'hC, 1, 1, 32'hB, 1};
        vt[4]  = '{1, 1, 0, 32'hC, 1, 1, 32'hC, 2};
        vt[5]  = '{0, 1, 0, 32'h0, 0, 1, 32'h0, 3};
        vt[6]  = '{1, 0, 0, 32'hD, 1, 1, 32'hD, 3};
        vt[7]  = '{1, 0, 0, 32'hE, 1, 0, 32'hD, 3};
        vt[8]  = '{1, 0, 1, 32'hF, 0, 1, 32'h0, 3};
        vt[9]  = '{1, 0, 0, 32'h6, 1, 1, 32'h6, 3};
        vt[10] = '{1, 1, 1, 32'h7, 0, 1, 32'h0, 4};
        vt[11] = '{0, 0, 0, 32'h0, 0, 1, 32'h0, 4};
        base = retired;
        for (int i = 0; i < 12; i++) begin
            in_valid = vt[i].v; out_ready = vt[i].ordy; flush = vt[i].fl;
            drv = '0; drv.wreg = 1'b1; drv.alu = vt[i].alu;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vt[i].exp_ir));
            chk($sformatf("vec%0d_wreg", i), 32'(out_wreg), 32'(vt[i].exp_ov));
            chk($sformatf("vec%0d_ret", i), 32'(retired), 32'(base + RET_W'(vt[i].exp_ret)));
            if (vt[i].exp_ov) chk($sformatf("vec%0d_alu", i), out_alu_out, vt[i].exp_alu);
        end
        flush = 1'b0;

        // Counter wrap: 17 drains from reset gives 1 with a 4-bit counter.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; drv = '0; drv.alu = 32'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_retired", 32'(retired), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            drv.wreg  = 1'($urandom);
            drv.m2reg = 1'($urandom);
            drv.mem   = $urandom;
            drv.alu   = $urandom;
            drv.rdrt  = 5'($urandom);
            drv.typ   = 4'($urandom);
            drv.num   = 4'($urandom);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset mid-operation while FULL.
        in_valid = 1'b1; out_ready = 1'b0;
        step(); step();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_ret", 32'(retired), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
